pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the MIPS32 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and PC.
- Issues per-stage write-enable, flush and bubble controls.
- Resolves three hazard classes:
  - load-use stalls;
  - taken-branch flushes, with the branch resolved in MEM from the EX/MEM branch and zero outputs;
  - variable-latency data-memory waits, with a timeout.

---
 rtl/mips_pkg.sv | 6 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 12 +
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline-control types and constants
package mips_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} ctrl_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MEM_TIMEOUT_DEF = 16;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use comparator between the ID/EX load and the IF/ID sources
module hazard_detect
    import mips_pkg::*;
(
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    output logic       lu
);
    assign lu = id_ex_mem_read && id_ex_rt != REG_ZERO && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: MIPS pipeline stall/flush sequencer; PIPE_HAZARD_CTRL_PERF_CNT_EN adds perf counters
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    parameter int CNT_W = 32,
`endif
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    input  logic       ex_mem_branch,
    input  logic       ex_mem_z,
    input  logic       ex_mem_mem_read,
    input  logic       ex_mem_mem_write,
    input  logic       dmem_ready,
    output logic       dmem_req,
    output logic       pc_write,
    output logic       pc_src,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_flush,
    output logic       ex_mem_write,
    output logic       ex_mem_flush,
    output logic       mem_wb_bubble,
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_lu_cnt,
`endif
    output logic       halted
);
    ctrl_state_t state, state_nx;
    logic [7:0] wait_cnt, cnt_nx;
    logic lu, taken, memop, lu_stall, flush_ev;

    assign taken = ex_mem_branch && ex_mem_z;
    assign memop = ex_mem_mem_read || ex_mem_mem_write;
    assign halted = state == HALT;

    hazard_detect u_hd (
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs),
        .if_id_rt(if_id_rt),
        .lu(lu)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            wait_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx = wait_cnt;
        if (state == RUN && !taken && memop && !dmem_ready) begin
            state_nx = MEM_WAIT;
            cnt_nx = '0;
        end else if (state == MEM_WAIT) begin
            cnt_nx = wait_cnt + 8'd1;
            state_nx = dmem_ready ? RUN : (wait_cnt == 8'(MEM_TIMEOUT - 1)) ? HALT : MEM_WAIT;
        end
    end

    always_comb begin
        dmem_req = 1'b0;
        pc_write = 1'b1;
        pc_src = 1'b0;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_write = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_write = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_bubble = 1'b0;
        lu_stall = 1'b0;
        flush_ev = 1'b0;
        if (state == HALT || (state == MEM_WAIT && !dmem_ready)) begin
            dmem_req = state == MEM_WAIT;
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
            mem_wb_bubble = 1'b1;
        end else if (state == RUN && taken) begin
            pc_src = 1'b1;
            {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
            flush_ev = 1'b1;
        end else begin
            // a completed MEM_WAIT lands here too, so a pending load-use still gets its bubble
            dmem_req = memop;
            if (memop && !dmem_ready) begin
                {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
                mem_wb_bubble = 1'b1;
            end else if (lu) begin
                pc_write = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                lu_stall = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flush_cnt <= '0;
            perf_lu_cnt <= '0;
        end else begin
            if (!pc_write && ~&perf_stall_cycles) perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
            if (flush_ev && ~&perf_flush_cnt) perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            if (lu_stall && ~&perf_lu_cnt) perf_lu_cnt <= perf_lu_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_ev;
    assign unused_ev = lu_stall ^ flush_ev;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, flush, memory-wait and timeout control
module tb_pipe_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [4:0] if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
    logic id_ex_mem_read = 0, ex_mem_branch = 0, ex_mem_z = 0;
    logic ex_mem_mem_read = 0, ex_mem_mem_write = 0, dmem_ready = 0;
    logic dmem_req, pc_write, pc_src, if_id_write, if_id_flush, id_ex_write;
    logic id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_bubble, halted;
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_cnt, perf_lu_cnt;
`endif
    int errors = 0;
    int checks = 0;
    logic [10:0] ctl;

    localparam logic [10:0] IDLE  = 11'b01010101000;
    localparam logic [10:0] LUS   = 11'b00000111000;
    localparam logic [10:0] TAKEN = 11'b01111111100;
    localparam logic [10:0] MEMOK = 11'b11010101000;
    localparam logic [10:0] MSTL  = 11'b10000000010;
    localparam logic [10:0] MLU   = 11'b10000111000;
    localparam logic [10:0] HLT   = 11'b00000000011;

    always #5 clock = ~clock;

    assign ctl = {dmem_req, pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
                  id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_bubble, halted};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .ex_mem_branch(ex_mem_branch), .ex_mem_z(ex_mem_z),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_write(pc_write), .pc_src(pc_src),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
        .mem_wb_bubble(mem_wb_bubble),
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_cnt(perf_flush_cnt),
        .perf_lu_cnt(perf_lu_cnt),
`endif
        .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] irt,
                         input logic br, input logic z, input logic mr, input logic mw, input logic rdy);
        id_ex_mem_read = rd; id_ex_rt = rt; if_id_rs = rs; if_id_rt = irt;
        ex_mem_branch = br; ex_mem_z = z; ex_mem_mem_read = mr; ex_mem_mem_write = mw; dmem_ready = rdy;
        #1;
    endtask

    task automatic step(input string tag, input logic [10:0] exp);
        chk(tag, 32'(ctl), 32'(exp));
        tick();
    endtask

    initial begin
        tick(); tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("reset_idle", IDLE);
        drive(1, 8, 8, 0, 0, 0, 0, 0, 0); step("lu_rs", LUS);
        drive(0, 0, 8, 0, 0, 0, 0, 0, 0); step("lu_bubble", IDLE);
        drive(1, 9, 3, 9, 0, 0, 0, 0, 0); step("lu_rt", LUS);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("lu_r0", IDLE);
        drive(0, 8, 8, 8, 0, 0, 0, 0, 0); step("no_load", IDLE);
        drive(1, 8, 8, 0, 1, 1, 0, 0, 0); step("taken_lu", TAKEN);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step("not_taken", IDLE);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("mem_miss", MSTL);
        drive(0, 0, 0, 0, 1, 1, 1, 0, 0); step("wait0_taken", MSTL);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("wait1", MSTL);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1); step("wait_done", MEMOK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("after_wait", IDLE);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("st_miss", MSTL);
        drive(1, 8, 8, 0, 0, 0, 0, 1, 1); step("wait_done_lu", MLU);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("after_lu", IDLE);
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
        chk("perf_lu", perf_lu_cnt, 32'd3);
        chk("perf_flush", perf_flush_cnt, 32'd1);
        chk("perf_stall", perf_stall_cycles, 32'd7);
`endif
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("to_miss", MSTL);
        for (int i = 0; i < 4; i++) step($sformatf("to_wait%0d", i), MSTL);
        step("halt", HLT);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step("halt_sticky", HLT);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("halt_reset", IDLE);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("rst_miss", MSTL);
        chk("rst_in_wait", 32'(ctl), 32'(MSTL));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("wait_reset", IDLE);
        step("wait_reset_run", IDLE);
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
        chk("perf_cleared", perf_stall_cycles, 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
